// File: rtl/motor_pkg.sv
// Shared types for the motor command sequencer: direction codes, FSM states
// and small direction helpers.
package motor_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_STOP = 2'b00;
  localparam dir_t DIR_FWD  = 2'b01;
  localparam dir_t DIR_REV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    RUN
  } state_t;

  // Code 11 carries no motion and is handled as STOP.
  function automatic dir_t dir_norm(input dir_t d);
    return (d == DIR_FWD || d == DIR_REV) ? d : DIR_STOP;
  endfunction

  function automatic logic is_reversal(input dir_t nd, input dir_t ld);
    return (nd == DIR_FWD && ld == DIR_REV) || (nd == DIR_REV && ld == DIR_FWD);
  endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Manual and autonomous command channels (valid/ready with direction and duration).
interface motor_cmd_sequencer_if #(
  parameter int unsigned DUR_W = 16
);
  import motor_pkg::*;

  logic             m_valid;
  logic             m_ready;
  dir_t             m_dir;
  logic [DUR_W-1:0] m_dur;
  logic             a_valid;
  logic             a_ready;
  dir_t             a_dir;
  logic [DUR_W-1:0] a_dur;

  modport master (
    output m_valid, m_dir, m_dur, a_valid, a_dir, a_dur,
    input  m_ready, a_ready
  );

  modport slave (
    input  m_valid, m_dir, m_dur, a_valid, a_dir, a_dur,
    output m_ready, a_ready
  );
endinterface

// File: rtl/motor_cmd_sequencer_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags tick on the last count.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/motor_cmd_sequencer.sv
// Arbitrates manual/autonomous drive commands, times them in ms ticks and
// inserts a stop dead-time before any direction reversal.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_DIV = CLK_HZ / 1000,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned DEAD_MS  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  motor_cmd_sequencer_if.slave cmd,
  output logic                 forward,
  output logic                 backward,
  output logic                 busy,
  output logic                 src,
  output logic                 done
);
  localparam int unsigned CW = $clog2(DEAD_MS + 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_MS - 1);
  localparam logic [CW-1:0] DEAD_FULL = CW'(DEAD_MS);

  state_t           state;
  dir_t             cur_dir;
  dir_t             last_dir;
  logic [DUR_W-1:0] rem;
  logic [CW-1:0]    dead_cnt;
  logic [CW-1:0]    idle_ms;
  logic             long_cmd;
  logic             tick;
  logic             m_acc;
  logic             a_acc;
  logic             acc;
  dir_t             new_dir;
  logic [DUR_W-1:0] new_dur;

  assign cmd.m_ready = (state == IDLE) || !src;
  assign cmd.a_ready = (state == IDLE) && !cmd.m_valid;

  always_comb begin
    m_acc   = cmd.m_valid && cmd.m_ready;
    a_acc   = cmd.a_valid && cmd.a_ready;
    acc     = m_acc || a_acc;
    new_dir = m_acc ? dir_norm(cmd.m_dir) : dir_norm(cmd.a_dir);
    new_dur = m_acc ? cmd.m_dur : cmd.a_dur;
  end

  // Accept also restarts the prescaler, which covers DEAD entry.
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_dir  <= DIR_STOP;
      last_dir <= DIR_STOP;
      rem      <= '0;
      dead_cnt <= '0;
      idle_ms  <= '0;
      long_cmd <= 1'b0;
      forward  <= 1'b0;
      backward <= 1'b0;
      busy     <= 1'b0;
      src      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (acc) begin
        cur_dir  <= new_dir;
        src      <= m_acc;
        rem      <= new_dur;
        dead_cnt <= '0;
        idle_ms  <= '0;
        long_cmd <= 32'(new_dur) >= DEAD_MS;
        if (new_dur == '0) begin
          state    <= IDLE;
          done     <= 1'b1;
          forward  <= 1'b0;
          backward <= 1'b0;
          busy     <= 1'b0;
        end else if (is_reversal(new_dir, last_dir)) begin
          state    <= DEAD;
          forward  <= 1'b0;
          backward <= 1'b0;
          busy     <= 1'b1;
        end else begin
          state    <= RUN;
          forward  <= (new_dir == DIR_FWD);
          backward <= (new_dir == DIR_REV);
          busy     <= 1'b1;
          if (new_dir != DIR_STOP) last_dir <= new_dir;
        end
      end else begin
        case (state)
          IDLE: begin
            if (tick && idle_ms < DEAD_FULL) begin
              idle_ms <= idle_ms + 1'b1;
              if (idle_ms == DEAD_LAST) last_dir <= DIR_STOP;
            end
          end
          DEAD: begin
            if (tick) begin
              if (dead_cnt == DEAD_LAST) begin
                state    <= RUN;
                forward  <= (cur_dir == DIR_FWD);
                backward <= (cur_dir == DIR_REV);
                last_dir <= cur_dir;
              end else begin
                dead_cnt <= dead_cnt + 1'b1;
              end
            end
          end
          RUN: begin
            if (tick) begin
              if (rem == DUR_W'(1)) begin
                state    <= IDLE;
                forward  <= 1'b0;
                backward <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                if (cur_dir == DIR_STOP && long_cmd) last_dir <= DIR_STOP;
              end else begin
                rem <= rem - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
